i2c_uart_bridge_ctrl: RTL

Sequencing controller between the I2C slave receiver and the UART transmitter of the I2C-to-UART bridge. It buffers data bytes received in an addressed I2C write frame in a FIFO, optionally appends an end-of-frame byte on STOP, and feeds the UART one byte at a time using a start/busy handshake. It also tells the I2C slave whether it can ACK the next byte, and reports overflow and UART-stall errors.

---
 rtl/i2c_uart_bridge_ctrl_if.sv | 24 ++
 rtl/i2c_uart_bridge_ctrl.sv | 77 +++++++
 2 files changed

// File: rtl/i2c_uart_bridge_ctrl_if.sv
// i2c_uart_bridge_ctrl_if: I2C receive, UART transmit and status signals of the bridge controller
interface i2c_uart_bridge_ctrl_if #(parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;
  logic i_frame_active;
  logic i_rx_valid;
  logic [7:0] i_rx_data;
  logic i_stop;
  logic o_rx_ready;
  logic o_tx_start;
  logic [7:0] o_tx_data;
  logic i_tx_busy;
  logic i_clr_err;
  logic o_overflow;
  logic o_tx_err;
  logic [CW-1:0] o_count;
  modport slave (
    input i_frame_active, i_rx_valid, i_rx_data, i_stop, i_tx_busy, i_clr_err,
    output o_rx_ready, o_tx_start, o_tx_data, o_overflow, o_tx_err, o_count
  );
  modport master (
    output i_frame_active, i_rx_valid, i_rx_data, i_stop, i_tx_busy, i_clr_err,
    input o_rx_ready, o_tx_start, o_tx_data, o_overflow, o_tx_err, o_count
  );
endinterface

// File: rtl/i2c_uart_bridge_ctrl.sv
// i2c_uart_bridge_ctrl: buffers I2C write-frame bytes, appends an end-of-frame byte on STOP and
// feeds the UART one byte per start/busy handshake, with overflow and UART-stall reporting.
module i2c_uart_bridge_ctrl #(
  parameter int DEPTH = 16,
  parameter bit EOF_EN = 1'b1,
  parameter logic [7:0] EOF_BYTE = 8'h0A,
  parameter int TIMEOUT = 64
) (
  input logic i_clk,
  input logic i_reset_n,
  i2c_uart_bridge_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT_ACC, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr, count;
  logic [TW-1:0] timer;
  logic eof_pend, frame_nonempty, full, empty;
  logic data_push, eof_push, push, pop, ovf_set, stop_hit, tmo;
  assign count = wr_ptr - rd_ptr;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign data_push = bus.i_rx_valid && bus.i_frame_active && !full;
  assign ovf_set = bus.i_rx_valid && bus.i_frame_active && full;
  assign eof_push = EOF_EN && eof_pend && !data_push && !full;
  assign push = data_push || eof_push;
  // a byte arriving with STOP still counts toward the frame, so its EOF follows next cycle
  assign stop_hit = bus.i_stop && (frame_nonempty || data_push);
  assign bus.o_rx_ready = !full && !eof_pend;
  assign bus.o_count = count;
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr[AW-1:0]] <= data_push ? bus.i_rx_data : EOF_BYTE;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : WAIT_ACC;
      end
      WAIT_ACC: begin
        tmo = !bus.i_tx_busy && timer == TW'(TIMEOUT - 1);
        state_n = bus.i_tx_busy ? WAIT_DONE : tmo ? IDLE : WAIT_ACC;
      end
      WAIT_DONE: state_n = bus.i_tx_busy ? WAIT_DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      timer <= '0;
      eof_pend <= 1'b0;
      frame_nonempty <= 1'b0;
      bus.o_tx_start <= 1'b0;
      bus.o_tx_data <= 8'h00;
      bus.o_overflow <= 1'b0;
      bus.o_tx_err <= 1'b0;
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr + CW'(push);
      rd_ptr <= rd_ptr + CW'(pop);
      timer <= pop ? '0 : state == WAIT_ACC ? timer + 1'b1 : timer;
      eof_pend <= (EOF_EN && stop_hit) || (eof_pend && !eof_push);
      frame_nonempty <= stop_hit ? 1'b0 : frame_nonempty || data_push;
      bus.o_tx_start <= pop;
      if (pop) bus.o_tx_data <= mem[rd_ptr[AW-1:0]];
      bus.o_overflow <= ovf_set || (bus.o_overflow && !bus.i_clr_err);
      bus.o_tx_err <= tmo || (bus.o_tx_err && !bus.i_clr_err);
    end
endmodule
